// File: rtl/fetch_ctrl_if.sv
// Instruction SRAM request/response channel between the fetch sequencer and the SRAM.
`timescale 1ns/1ps
interface fetch_ctrl_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Pre-IF fetch sequencer: owns the PC, runs one SRAM fetch at a time, buffers the word
// for ID, and discards words made stale by a branch redirect.
`timescale 1ns/1ps
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ds_allow_in,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [31:0]         br_target,
  fetch_ctrl_if.master        inst_sram,
  output logic                fs_to_ds_valid,
  output logic [31:0]         fs_pc,
  output logic [31:0]         fs_inst
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state,      w_state_nxt;
  logic [31:0] r_pc,         w_pc_nxt;
  logic [31:0] r_pend_pc,    w_pend_pc_nxt;
  logic [31:0] r_fs_pc,      w_fs_pc_nxt;
  logic [31:0] r_fs_inst,    w_fs_inst_nxt;
  logic        r_discard,    w_discard_nxt;
  logic        r_redir_pend, w_redir_pend_nxt;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_pend_pc    <= RESET_PC;
      r_fs_pc      <= RESET_PC;
      r_fs_inst    <= 32'h0;
      r_discard    <= 1'b0;
      r_redir_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_fs_pc      <= w_fs_pc_nxt;
      r_fs_inst    <= w_fs_inst_nxt;
      r_discard    <= w_discard_nxt;
      r_redir_pend <= w_redir_pend_nxt;
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_pc_nxt    = r_pend_pc;
    w_fs_pc_nxt      = r_fs_pc;
    w_fs_inst_nxt    = r_fs_inst;
    w_discard_nxt    = r_discard;
    w_redir_pend_nxt = r_redir_pend;

    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (br_taken) w_pc_nxt = br_target;
      end

      S_REQ: begin
        if (inst_sram.inst_sram_addr_ok) begin
          w_state_nxt      = S_WAIT;
          w_redir_pend_nxt = 1'b0;
          // The address already accepted is the old PC, so its word must be dropped.
          if (br_taken) begin
            w_discard_nxt = 1'b1;
            w_pc_nxt      = br_target;
          end else if (r_redir_pend) begin
            w_discard_nxt = 1'b1;
            w_pc_nxt      = r_pend_pc;
          end
        end else if (br_taken) begin
          // Address must stay stable until accepted; park the target instead.
          w_redir_pend_nxt = 1'b1;
          w_pend_pc_nxt    = br_target;
        end
      end

      S_WAIT: begin
        if (inst_sram.inst_sram_data_ok) begin
          w_discard_nxt = 1'b0;
          if (br_taken) begin
            w_pc_nxt    = br_target;
            w_state_nxt = S_REQ;
          end else if (r_discard) begin
            w_state_nxt = S_REQ;
          end else begin
            w_fs_inst_nxt = inst_sram.inst_sram_rdata;
            w_fs_pc_nxt   = r_pc;
            w_state_nxt   = S_HOLD;
          end
        end else if (br_taken) begin
          w_discard_nxt = 1'b1;
          w_pc_nxt      = br_target;
        end
      end

      S_HOLD: begin
        if (br_taken) begin
          w_pc_nxt    = br_target;
          w_state_nxt = S_REQ;
        end else if (ds_allow_in && !stall) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_REQ;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign inst_sram.inst_sram_req  = (r_state == S_REQ);
  assign inst_sram.inst_sram_addr = r_pc;
  assign fs_to_ds_valid           = (r_state == S_HOLD);
  assign fs_pc                    = r_fs_pc;
  assign fs_inst                  = r_fs_inst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle vectors plus a scoreboard of words
// that must reach ID, popped whenever fs_to_ds_valid rises.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam logic [31:0] JUNK   = 32'hdeadbeef;
  localparam logic [31:0] D0 = 32'h00000013, D1 = 32'h00100093, D2 = 32'h02800413;
  localparam logic [31:0] D3 = 32'h0040a023, D4 = 32'h00c58633, D5 = 32'h1c0000b7;

  typedef struct {
    logic        ds, st, br;
    logic [31:0] tgt;
    logic        aok, dok;
    logic [31:0] rdata;
    logic        keep;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        chk_buf;
    logic [31:0] pc, inst;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        ds_allow_in, stall, br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc, fs_inst;

  fetch_ctrl_if sram_if ();

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allow_in    (ds_allow_in),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .inst_sram      (sram_if),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst)
  );

  int  n_checks = 0;
  int  n_errors = 0;
  sb_t sb_q[$];
  sb_t sb_e;
  logic prev_valid = 1'b0;
  vec_t tbl[15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ds, st, br, input logic [31:0] tgt,
                              input logic aok, dok, input logic [31:0] rdata,
                              input logic keep, req, input logic [31:0] addr,
                              input logic valid, chk_buf, input logic [31:0] pc, inst);
    vec_t v;
    v.ds = ds; v.st = st; v.br = br; v.tgt = tgt; v.aok = aok; v.dok = dok;
    v.rdata = rdata; v.keep = keep; v.req = req; v.addr = addr; v.valid = valid;
    v.chk_buf = chk_buf; v.pc = pc; v.inst = inst;
    return v;
  endfunction

  // Short form for hand-written rows: buffer contents are left to the scoreboard.
  function automatic vec_t hv(input logic ds, br, input logic [31:0] tgt,
                              input logic aok, dok, input logic [31:0] rdata,
                              input logic keep, req, input logic [31:0] addr,
                              input logic valid);
    return mk(ds, 1'b0, br, tgt, aok, dok, rdata, keep, req, addr, valid, 1'b0, 32'h0, 32'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, check the state-decoded outputs of that cycle, advance.
  task automatic apply(input vec_t v, input string tag);
    ds_allow_in                = v.ds;
    stall                      = v.st;
    br_taken                   = v.br;
    br_target                  = v.tgt;
    sram_if.inst_sram_addr_ok  = v.aok;
    sram_if.inst_sram_data_ok  = v.dok;
    sram_if.inst_sram_rdata    = v.rdata;
    if (v.keep) sb_q.push_back('{pc: v.addr, inst: v.rdata});
    check({tag, "_req"},   {31'h0, sram_if.inst_sram_req}, {31'h0, v.req});
    check({tag, "_addr"},  sram_if.inst_sram_addr, v.addr);
    check({tag, "_valid"}, {31'h0, fs_to_ds_valid}, {31'h0, v.valid});
    if (v.chk_buf) begin
      check({tag, "_fs_pc"},   fs_pc,   v.pc);
      check({tag, "_fs_inst"}, fs_inst, v.inst);
    end
    tick();
  endtask

  always @(posedge clk) begin
    #2;
    if (fs_to_ds_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: valid word pc %h inst %h, none expected", fs_pc, fs_inst);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_pc",   fs_pc,   sb_e.pc);
        check("sb_inst", fs_inst, sb_e.inst);
      end
    end
    prev_valid = fs_to_ds_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release, first fetch, long HOLD with ds_allow_in low then stall high.
    tbl[0]  = mk(0,0,0,0, 0,0,0,    0, 0,RST_PC,            0, 1,RST_PC,            0);
    tbl[1]  = mk(0,0,0,0, 1,0,0,    0, 1,RST_PC,            0, 1,RST_PC,            0);
    tbl[2]  = mk(0,0,0,0, 0,1,D0,   1, 0,RST_PC,            0, 1,RST_PC,            0);
    tbl[3]  = mk(0,0,0,0, 0,0,0,    0, 0,RST_PC,            1, 1,RST_PC,            D0);
    tbl[4]  = mk(0,0,0,0, 0,0,0,    0, 0,RST_PC,            1, 1,RST_PC,            D0);
    tbl[5]  = mk(0,0,0,0, 1,0,0,    0, 0,RST_PC,            1, 1,RST_PC,            D0);
    tbl[6]  = mk(0,0,0,0, 0,1,JUNK, 0, 0,RST_PC,            1, 1,RST_PC,            D0);
    tbl[7]  = mk(0,0,0,0, 0,0,0,    0, 0,RST_PC,            1, 1,RST_PC,            D0);
    tbl[8]  = mk(1,1,0,0, 0,0,0,    0, 0,RST_PC,            1, 1,RST_PC,            D0);
    tbl[9]  = mk(1,1,0,0, 0,0,0,    0, 0,RST_PC,            1, 1,RST_PC,            D0);
    tbl[10] = mk(1,0,0,0, 0,0,0,    0, 0,RST_PC,            1, 1,RST_PC,            D0);
    tbl[11] = mk(0,0,0,0, 1,0,0,    0, 1,32'h1c000004,      0, 1,RST_PC,            D0);
    tbl[12] = mk(0,0,0,0, 0,1,D1,   1, 0,32'h1c000004,      0, 1,RST_PC,            D0);
    tbl[13] = mk(1,0,0,0, 0,0,0,    0, 0,32'h1c000004,      1, 1,32'h1c000004,      D1);
    tbl[14] = mk(0,0,0,0, 0,0,0,    0, 1,32'h1c000008,      0, 1,32'h1c000004,      D1);

    reset = 1'b0;
    ds_allow_in = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    sram_if.inst_sram_addr_ok = 1'b0;
    sram_if.inst_sram_data_ok = 1'b0;
    sram_if.inst_sram_rdata   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("t%0d", i));

    // Redirect in WAIT, stale word returns two cycles later.
    apply(hv(0,0,0,            1,0,0,    0, 1,32'h1c000008, 0), "w_a");
    apply(hv(0,1,32'h1c000100, 0,0,0,    0, 0,32'h1c000008, 0), "w_b");
    apply(hv(0,0,0,            0,0,0,    0, 0,32'h1c000100, 0), "w_c");
    apply(hv(0,0,0,            0,1,JUNK, 0, 0,32'h1c000100, 0), "w_d");
    apply(hv(0,0,0,            1,0,0,    0, 1,32'h1c000100, 0), "w_e");

    // Redirect in REQ with addr_ok held off; a second redirect overwrites the first.
    apply(hv(0,0,0,            0,1,D2,   1, 0,32'h1c000100, 0), "r_f");
    apply(hv(1,0,0,            0,0,0,    0, 0,32'h1c000100, 1), "r_g");
    apply(hv(0,1,32'h1c000300, 0,0,0,    0, 1,32'h1c000104, 0), "r_h");
    apply(hv(0,1,32'h1c000100, 0,0,0,    0, 1,32'h1c000104, 0), "r_i");
    apply(hv(0,0,0,            0,0,0,    0, 1,32'h1c000104, 0), "r_j");
    apply(hv(0,0,0,            1,0,0,    0, 1,32'h1c000104, 0), "r_k");
    apply(hv(0,0,0,            0,1,JUNK, 0, 0,32'h1c000100, 0), "r_l");

    // Redirect with data_ok, with a hand-off in HOLD, and with addr_ok in REQ.
    apply(hv(0,0,0,            1,0,0,    0, 1,32'h1c000100, 0), "s_m");
    apply(hv(0,1,32'h1c000400, 0,1,JUNK, 0, 0,32'h1c000100, 0), "s_n");
    apply(hv(0,0,0,            1,0,0,    0, 1,32'h1c000400, 0), "s_o");
    apply(hv(0,0,0,            0,1,D3,   1, 0,32'h1c000400, 0), "s_p");
    apply(hv(1,1,32'h1c000500, 0,0,0,    0, 0,32'h1c000400, 1), "s_q");
    apply(hv(0,1,32'h1c000600, 1,0,0,    0, 1,32'h1c000500, 0), "s_r");
    apply(hv(0,0,0,            0,1,JUNK, 0, 0,32'h1c000600, 0), "s_s");

    // PC wrap at the top of the address space, then reset mid-fetch.
    apply(hv(0,0,0,            1,0,0,    0, 1,32'h1c000600, 0), "p_t");
    apply(hv(0,1,32'hfffffffc, 0,1,JUNK, 0, 0,32'h1c000600, 0), "p_u");
    apply(hv(0,0,0,            1,0,0,    0, 1,32'hfffffffc, 0), "p_v");
    apply(hv(0,0,0,            0,1,D4,   1, 0,32'hfffffffc, 0), "p_w");
    apply(hv(1,0,0,            0,0,0,    0, 0,32'hfffffffc, 1), "p_x");
    apply(hv(0,0,0,            1,0,0,    0, 1,32'h00000000, 0), "p_y");

    ds_allow_in = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    sram_if.inst_sram_addr_ok = 1'b0;
    sram_if.inst_sram_data_ok = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_req",     {31'h0, sram_if.inst_sram_req}, 32'h0);
    check("rst_addr",    sram_if.inst_sram_addr, RST_PC);
    check("rst_valid",   {31'h0, fs_to_ds_valid}, 32'h0);
    check("rst_fs_pc",   fs_pc, RST_PC);
    check("rst_fs_inst", fs_inst, 32'h0);
    tick();
    reset = 1'b1;

    apply(hv(0,0,0, 0,0,0,  0, 0,RST_PC, 0), "z_0");
    apply(hv(0,0,0, 1,0,0,  0, 1,RST_PC, 0), "z_1");
    apply(hv(0,0,0, 0,1,D5, 1, 0,RST_PC, 0), "z_2");
    check("z_3_valid",   {31'h0, fs_to_ds_valid}, 32'h1);
    check("z_3_fs_pc",   fs_pc, RST_PC);
    check("z_3_fs_inst", fs_inst, D5);
    repeat (2) tick();
    check("sb_empty", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
